// File: rtl/diag_bus_app.sv
// diag_bus_app: bus diagnostic app with scratch, patterns, counters and loopback FIFO.
// Define DIAG_LFSR_EN to map a 16-bit LFSR at window offset 0x22.
module diag_bus_app #(
  parameter int DATA_W      = 16,
  parameter int AB_W        = 8,
  parameter int BASE_ADDR   = 0,
  parameter int NUM_SCRATCH = 4,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic              xclk,
  input  logic              reset,
  input  logic              write_qualified,
  input  logic              read_qualified,
  input  logic [AB_W-1:0]   ab,
  input  logic [DATA_W-1:0] db_in,
  output logic [DATA_W-1:0] db_out_DA,
  output logic              data_from_DA_avail
);

  localparam int CW = 2 * DATA_W;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [AB_W:0] BASE = (AB_W+1)'(BASE_ADDR);
  localparam logic [AB_W:0] WIN = (AB_W+1)'(64);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] ONES = '1;

  function automatic logic [DATA_W-1:0] nib_pat(input logic [7:0] b);
    logic [DATA_W-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_W; i++) p[i] = b[i[2:0]];
    return p;
  endfunction

  localparam logic [DATA_W-1:0] PAT_A5 = nib_pat(8'hA5);
  localparam logic [DATA_W-1:0] PAT_5A = nib_pat(8'h5A);

  logic [AB_W:0]   rel;
  logic            in_win;
  logic            wr;
  logic            rd;
  logic [5:0]      off;

  assign rel    = {1'b0, ab} - BASE;
  assign in_win = rel < WIN;
  assign off    = rel[5:0];
  assign wr     = write_qualified & in_win;
  assign rd     = read_qualified & in_win;

  logic [DATA_W-1:0] scr_q [NUM_SCRATCH];
  logic [DATA_W-1:0] scr_d [NUM_SCRATCH];
  logic [DATA_W-1:0] scr_x;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              avail_q, avail_d;

  logic              empty, full;
  logic              do_push, do_pop;
  logic              push_ok, pop_ok;
  logic [15:0]       stat;
  logic [DATA_W-1:0] rdata;
  logic              rmap;

  assign empty   = cnt_q == '0;
  assign full    = cnt_q == DEPTH;
  assign do_push = wr & (off == 6'h20);
  assign do_pop  = rd & (off == 6'h20);
  // A pop frees the slot that a same-cycle push into a full FIFO uses
  assign pop_ok  = do_pop & ~empty;
  assign push_ok = do_push & (~full | pop_ok);
  assign stat    = {ovf_q, unf_q, full, empty, 12'(cnt_q)};

`ifdef DIAG_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_comb begin
    lfsr_d = lfsr_q;
    if (wr && off == 6'h22) begin
      lfsr_d = (db_in[15:0] == 16'h0000) ? 16'h0001 : db_in[15:0];
    end else if (rd && off == 6'h22) begin
      lfsr_d = {lfsr_fb, lfsr_q[15:1]};
    end
  end

  always_ff @(posedge xclk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`endif

  always_comb begin
    scr_x = '0;
    for (int i = 0; i < NUM_SCRATCH; i++) scr_x ^= scr_q[i];
  end

  always_comb begin
    rdata = ONES;
    rmap  = 1'b0;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (off == 6'(i)) begin
        rdata = scr_q[i];
        rmap  = 1'b1;
      end
    end
    case (off)
      6'h10: begin rdata = scr_x;  rmap = 1'b1; end
      6'h11: begin rdata = '0;     rmap = 1'b1; end
      6'h12: begin rdata = ONES;   rmap = 1'b1; end
      6'h13: begin rdata = PAT_A5; rmap = 1'b1; end
      6'h14: begin rdata = PAT_5A; rmap = 1'b1; end
      6'h18: begin rdata = cyc_q[DATA_W-1:0]; rmap = 1'b1; end
      6'h19: begin rdata = snap_q; rmap = 1'b1; end
      6'h1A: begin rdata = acc_q;  rmap = 1'b1; end
      6'h20: begin
        rdata = empty ? ONES : mem_q[rd_ptr_q];
        rmap  = 1'b1;
      end
      6'h21: begin rdata = DATA_W'(stat); rmap = 1'b1; end
`ifdef DIAG_LFSR_EN
      6'h22: begin rdata = DATA_W'(lfsr_q); rmap = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    scr_d = scr_q;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (wr && off == 6'(i)) scr_d[i] = db_in;
    end
    cyc_d = cyc_q + CW'(1);
    if (wr && off == 6'h18) cyc_d = '0;
    snap_d = snap_q;
    if (rd && off == 6'h18) snap_d = cyc_q[CW-1:DATA_W];
    acc_d = acc_q;
    if (wr && off == 6'h1A)  acc_d = db_in;
    else if (rd && !wr)      acc_d = acc_q + DATA_W'(1);
    else if (wr && !rd)      acc_d = acc_q - DATA_W'(1);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    cnt_d    = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    ovf_d    = ovf_q | (do_push & ~push_ok);
    unf_d    = unf_q | (do_pop & empty);
    if (wr && off == 6'h21) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    dout_d  = dout_q;
    avail_d = avail_q;
    if (read_qualified) begin
      dout_d  = (in_win && rmap) ? rdata : ONES;
      avail_d = in_win & rmap;
    end
  end

  always_ff @(posedge xclk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scr_q[i] <= '0;
      cyc_q    <= '0;
      snap_q   <= '0;
      acc_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
      avail_q  <= 1'b0;
    end else begin
      scr_q    <= scr_d;
      cyc_q    <= cyc_d;
      snap_q   <= snap_d;
      acc_q    <= acc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
      avail_q  <= avail_d;
    end
  end

  always_ff @(posedge xclk) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= db_in;
  end

  assign db_out_DA          = dout_q;
  assign data_from_DA_avail = avail_q;

endmodule
